// File: rtl/game_pkg.sv
// Shared game types and constants: enemy state encoding, sprite frame offsets, screen geometry.
package game_pkg;

    typedef enum logic [2:0] {
        WALK_L = 3'd0,
        WALK_R = 3'd1,
        ATTACK = 3'd2,
        DYING  = 3'd3,
        DEAD   = 3'd4
    } enemy_state_e;

    localparam int SCREEN_W      = 640;
    localparam int SCREEN_H      = 480;
    localparam int GROUND_Y      = 440;

    localparam int FRAME_STRIDE_DEF = 50;
    localparam int RIGHT_BASE_DEF   = 0;
    localparam int LEFT_BASE_DEF    = 250;
    localparam int ATK_R_OFS_DEF    = 200;
    localparam int ATK_L_OFS_DEF    = 450;
    localparam int DEAD_OFS_DEF     = 600;

endpackage

// File: rtl/enemy_actor.sv
// One patrolling enemy: walk/attack/dying FSM with hp, walk-cycle index and sprite frame.
// kill_o and touch_o are same-cycle pulses qualified by tick; the parent registers them.
module enemy_actor
    import game_pkg::*;
#(
    parameter int CW           = 10,
    parameter int ENEMY_W      = 50,
    parameter int PLAYER_W     = 50,
    parameter int SPEED        = 7,
    parameter int X_MIN        = 10,
    parameter int X_MAX        = 580,
    parameter int HP_INIT      = 3,
    parameter int FRAME_STRIDE = FRAME_STRIDE_DEF,
    parameter int WALK_FRAMES  = 4,
    parameter int RIGHT_BASE   = RIGHT_BASE_DEF,
    parameter int LEFT_BASE    = LEFT_BASE_DEF,
    parameter int ATK_R_OFS    = ATK_R_OFS_DEF,
    parameter int ATK_L_OFS    = ATK_L_OFS_DEF,
    parameter int DEAD_OFS     = DEAD_OFS_DEF,
    parameter int DYING_TICKS  = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          tick_i,
    input  logic          anim_tick_i,
    input  logic          level_start_i,
    input  logic [CW-1:0] spawn_x_i,
    input  logic [CW-1:0] spawn_y_i,
    input  logic [CW-1:0] player_x_i,
    input  logic [CW-1:0] player_y_i,
    input  logic          hit_req_i,
    output logic [CW-1:0] x_o,
    output logic [CW-1:0] y_o,
    output logic [CW-1:0] frame_o,
    output logic          alive_o,
    output logic          kill_o,
    output logic          touch_o
);
    localparam int HPW = (HP_INIT > 1) ? $clog2(HP_INIT + 1) : 1;
    localparam int IW  = (WALK_FRAMES > 1) ? $clog2(WALK_FRAMES) : 1;
    localparam int DW  = (DYING_TICKS > 1) ? $clog2(DYING_TICKS + 1) : 1;

    enemy_state_e  state_q, state_d;
    logic          dir_q, dir_d;
    logic [HPW-1:0] hp_q, hp_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [DW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] x_q, x_d, y_q, frame_q, frame_d;

    logic [CW:0]   x_ext, px_ext;
    logic          overlap, live, same_y;

    assign x_ext   = {1'b0, x_q};
    assign px_ext  = {1'b0, player_x_i};
    assign overlap = (x_ext < px_ext + (CW+1)'(PLAYER_W)) && (px_ext < x_ext + (CW+1)'(ENEMY_W));
    assign live    = (state_q == WALK_L) || (state_q == WALK_R) || (state_q == ATTACK);
    assign same_y  = (y_q == player_y_i);

    always_comb begin
        state_d = state_q;
        dir_d   = dir_q;
        hp_d    = hp_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        x_d     = x_q;
        frame_d = frame_q;
        kill_o  = 1'b0;
        touch_o = 1'b0;

        // Damage resolves before contact, so a killing blow suppresses this tick's touch.
        if (tick_i && live) begin
            if (hit_req_i) hp_d = hp_q - HPW'(1);
            if (hit_req_i && hp_q == HPW'(1)) begin
                state_d = DYING;
                frame_d = CW'(DEAD_OFS);
                cnt_d   = '0;
                kill_o  = 1'b1;
            end else if (state_q == ATTACK) begin
                if (!overlap) state_d = dir_q ? WALK_R : WALK_L;
                else          touch_o = same_y;
            end else if (overlap) begin
                state_d = ATTACK;
                touch_o = same_y;
            end else if (state_q == WALK_L) begin
                if (x_ext <= (CW+1)'(X_MIN + SPEED)) begin
                    x_d     = CW'(X_MIN);
                    state_d = WALK_R;
                    dir_d   = 1'b1;
                    idx_d   = '0;
                end else begin
                    x_d = x_q - CW'(SPEED);
                end
            end else begin
                if (x_ext + (CW+1)'(SPEED) >= (CW+1)'(X_MAX)) begin
                    x_d     = CW'(X_MAX);
                    state_d = WALK_L;
                    dir_d   = 1'b0;
                    idx_d   = '0;
                end else begin
                    x_d = x_q + CW'(SPEED);
                end
            end
        end

        if (anim_tick_i) begin
            case (state_d)
                WALK_L, WALK_R: begin
                    frame_d = CW'((state_d == WALK_R) ? RIGHT_BASE : LEFT_BASE)
                            + CW'(idx_d) * CW'(FRAME_STRIDE);
                    idx_d   = (idx_d == IW'(WALK_FRAMES - 1)) ? '0 : idx_d + IW'(1);
                end
                ATTACK: frame_d = CW'(dir_d ? ATK_R_OFS : ATK_L_OFS);
                DYING: begin
                    if (state_q == DYING) begin
                        if (cnt_q == DW'(DYING_TICKS - 1)) state_d = DEAD;
                        else                               cnt_d   = cnt_q + DW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= DEAD;
            dir_q   <= 1'b0;
            hp_q    <= '0;
            idx_q   <= '0;
            cnt_q   <= '0;
            x_q     <= '0;
            y_q     <= '0;
            frame_q <= '0;
        end else if (level_start_i) begin
            state_q <= WALK_L;
            dir_q   <= 1'b0;
            hp_q    <= HPW'(HP_INIT);
            idx_q   <= '0;
            cnt_q   <= '0;
            x_q     <= spawn_x_i;
            y_q     <= spawn_y_i;
            frame_q <= CW'(LEFT_BASE);
        end else begin
            state_q <= state_d;
            dir_q   <= dir_d;
            hp_q    <= hp_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            x_q     <= x_d;
            frame_q <= frame_d;
        end
    end

    assign x_o     = x_q;
    assign y_o     = y_q;
    assign frame_o = frame_q;
    assign alive_o = (state_q != DEAD);

endmodule

// File: rtl/enemy_patrol_engine.sv
// N patrolling enemies advancing on tick/anim_tick; attack edge detect, hit fan-out and
// player_hit / level_clear / kills reduction. All outputs change one cycle after their cause.
module enemy_patrol_engine
    import game_pkg::*;
#(
    parameter int N_ENEMIES    = 4,
    parameter int CW           = 10,
    parameter int ENEMY_W      = 50,
    parameter int PLAYER_W     = 50,
    parameter int SPEED        = 7,
    parameter int X_MIN        = 10,
    parameter int X_MAX        = SCREEN_W - 60,
    parameter int HP_INIT      = 3,
    parameter int ATK_REACH    = 10,
    parameter int FRAME_STRIDE = FRAME_STRIDE_DEF,
    parameter int WALK_FRAMES  = 4,
    parameter int RIGHT_BASE   = RIGHT_BASE_DEF,
    parameter int LEFT_BASE    = LEFT_BASE_DEF,
    parameter int ATK_R_OFS    = ATK_R_OFS_DEF,
    parameter int ATK_L_OFS    = ATK_L_OFS_DEF,
    parameter int DEAD_OFS     = DEAD_OFS_DEF,
    parameter int DYING_TICKS  = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    tick,
    input  logic                    anim_tick,
    input  logic                    level_start,
    input  logic [N_ENEMIES*CW-1:0] spawn_x,
    input  logic [N_ENEMIES*CW-1:0] spawn_y,
    input  logic [CW-1:0]           player_x,
    input  logic [CW-1:0]           player_y,
    input  logic                    facing,
    input  logic                    attack,
    output logic [N_ENEMIES*CW-1:0] enemy_x,
    output logic [N_ENEMIES*CW-1:0] enemy_y,
    output logic [N_ENEMIES*CW-1:0] enemy_frame,
    output logic [N_ENEMIES-1:0]    alive,
    output logic                    player_hit,
    output logic                    level_clear,
    output logic [3:0]              kills
);
    logic attack_q, atk_pend_q, atk_evt, started_q;
    logic player_hit_q, level_clear_q;
    logic [3:0] kills_q, kills_d;
    logic [4:0] kill_sum, kills_sum;
    logic [N_ENEMIES-1:0] hit_req, kill_vec, touch_vec;
    logic [CW+1:0] px2, reach;

    assign atk_evt = attack & ~attack_q;
    assign px2     = {2'b0, player_x};

    // Reach point in front of the player; the leftward one saturates at the screen edge.
    always_comb begin
        if (facing)
            reach = px2 + (CW+2)'(PLAYER_W + ATK_REACH);
        else if (px2 >= (CW+2)'(ATK_REACH))
            reach = px2 - (CW+2)'(ATK_REACH);
        else
            reach = '0;
    end

    for (genvar i = 0; i < N_ENEMIES; i++) begin : g_enemy
        logic [CW+1:0] ex2;
        assign ex2        = {2'b0, enemy_x[i*CW +: CW]};
        assign hit_req[i] = tick & atk_pend_q & (ex2 < reach) & (reach < ex2 + (CW+2)'(ENEMY_W));

        enemy_actor #(
            .CW(CW), .ENEMY_W(ENEMY_W), .PLAYER_W(PLAYER_W), .SPEED(SPEED),
            .X_MIN(X_MIN), .X_MAX(X_MAX), .HP_INIT(HP_INIT), .FRAME_STRIDE(FRAME_STRIDE),
            .WALK_FRAMES(WALK_FRAMES), .RIGHT_BASE(RIGHT_BASE), .LEFT_BASE(LEFT_BASE),
            .ATK_R_OFS(ATK_R_OFS), .ATK_L_OFS(ATK_L_OFS), .DEAD_OFS(DEAD_OFS),
            .DYING_TICKS(DYING_TICKS)
        ) u_actor (
            .clk          (clk),
            .rst          (rst),
            .tick_i       (tick),
            .anim_tick_i  (anim_tick),
            .level_start_i(level_start),
            .spawn_x_i    (spawn_x[i*CW +: CW]),
            .spawn_y_i    (spawn_y[i*CW +: CW]),
            .player_x_i   (player_x),
            .player_y_i   (player_y),
            .hit_req_i    (hit_req[i]),
            .x_o          (enemy_x[i*CW +: CW]),
            .y_o          (enemy_y[i*CW +: CW]),
            .frame_o      (enemy_frame[i*CW +: CW]),
            .alive_o      (alive[i]),
            .kill_o       (kill_vec[i]),
            .touch_o      (touch_vec[i])
        );
    end

    always_comb begin
        kill_sum = '0;
        for (int i = 0; i < N_ENEMIES; i++) kill_sum = kill_sum + 5'(kill_vec[i]);
        kills_sum = {1'b0, kills_q} + kill_sum;
        kills_d   = (kills_sum > 5'd15) ? 4'hF : kills_sum[3:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            attack_q      <= 1'b0;
            atk_pend_q    <= 1'b0;
            started_q     <= 1'b0;
            player_hit_q  <= 1'b0;
            level_clear_q <= 1'b0;
            kills_q       <= '0;
        end else begin
            attack_q   <= attack;
            // A press landing on a tick cycle is held for the following tick.
            atk_pend_q <= tick ? atk_evt : (atk_pend_q | atk_evt);
            if (level_start) begin
                started_q     <= 1'b1;
                player_hit_q  <= 1'b0;
                level_clear_q <= 1'b0;
                kills_q       <= '0;
            end else begin
                player_hit_q  <= player_hit_q | (|touch_vec);
                level_clear_q <= level_clear_q | (started_q & ~|alive);
                kills_q       <= kills_d;
            end
        end
    end

    assign player_hit  = player_hit_q;
    assign level_clear = level_clear_q;
    assign kills       = kills_q;

endmodule

// File: doc/enemy_patrol_engine.md
Name: enemy_patrol_engine

Overview:
- Parametrised successor to the hard-coded per-enemy game logic in the display top: N independent patrolling enemies, each with position, direction, hit points, animation frame offset and collision against the player.
- Runs on the single system clock and advances on game/animation tick enables instead of derived clocks.
- Sits between the input/player logic and the sprite controller; per-enemy x, y and frame outputs feed the sprite controller's memory-offset inputs.

Parameters:
- N_ENEMIES, 4, number of enemy instances (1..8)
- CW, 10, coordinate width in bits
- ENEMY_W, 50, enemy hitbox width in px
- PLAYER_W, 50, player hitbox width in px
- SPEED, 7, px moved per tick
- X_MIN, 10, left patrol bound
- X_MAX, 580, right patrol bound
- HP_INIT, 3, hits required to kill
- ATK_REACH, 10, attack reach beyond player edge in px
- FRAME_STRIDE, 50, memory offset between animation frames
- WALK_FRAMES, 4, walk cycle length
- RIGHT_BASE, 0, first right-walk frame offset
- LEFT_BASE, 250, first left-walk frame offset
- ATK_R_OFS, 200, right-attack frame offset
- ATK_L_OFS, 450, left-attack frame offset
- DEAD_OFS, 600, dead frame offset
- DYING_TICKS, 8, animation ticks the dead frame is shown before DEAD

Ports:
- clk, in, 1, system clock (100 MHz)
- rst, in, 1, synchronous active-high reset
- tick, in, 1, one-cycle movement enable
- anim_tick, in, 1, one-cycle animation enable
- level_start, in, 1, one-cycle pulse; respawn all enemies
- spawn_x, in, N_ENEMIES*CW, per-enemy spawn x; enemy i at [i*CW +: CW]
- spawn_y, in, N_ENEMIES*CW, per-enemy ground y
- player_x, in, CW, player left edge
- player_y, in, CW, player top edge
- facing, in, 1, 1 = player facing right
- attack, in, 1, attack button (level)
- enemy_x, out, N_ENEMIES*CW, current x per enemy
- enemy_y, out, N_ENEMIES*CW, current y per enemy
- enemy_frame, out, N_ENEMIES*CW, sprite memory offset per enemy
- alive, out, N_ENEMIES, 1 while enemy is not DEAD
- player_hit, out, 1, sticky; player touched by live enemy
- level_clear, out, 1, sticky; all enemies DEAD
- kills, out, 4, enemies killed since level_start (saturates at 15)

Behaviour:
- Reset: every enemy in DEAD; x = y = frame = 0; alive = 0; player_hit = 0; level_clear = 0; kills = 0; attack-edge register = 0.
- level_start (priority over everything except rst): next cycle each enemy is WALK_L with x = spawn_x[i], y = spawn_y[i], hp = HP_INIT, frame = LEFT_BASE, anim index 0; player_hit, level_clear and kills cleared; alive = all ones.
- Attack edge: atk_evt = attack & ~attack_q, registered every cycle. atk_evt is latched into atk_pend and consumed on the next tick, so one press gives one hit.
- Per-enemy FSM states: WALK_L, WALK_R, ATTACK, DYING, DEAD.
- WALK_L on tick:
  - x <= x - SPEED.
  - If x - SPEED <= X_MIN: clamp x = X_MIN, go to WALK_R.
  - Subtraction is done in CW+1 bits, so there is no underflow wrap.
- WALK_R on tick:
  - x <= x + SPEED.
  - If x + SPEED >= X_MAX: clamp x = X_MAX, go to WALK_L.
- Contact test: overlap = (x < player_x + PLAYER_W) && (player_x < x + ENEMY_W). The sums are computed in CW+1 bits.
- On tick, in WALK_L/R with overlap:
  - Go to ATTACK and hold x.
  - If y == player_y, set player_hit.
  - A player standing at a different y (jumping) is not hit.
- ATTACK on tick: no overlap returns the enemy to the walk state for its prior direction; overlap with y == player_y sets player_hit.
- Attack hit test, evaluated on the tick with atk_pend:
  - Facing right: reach point r = player_x + PLAYER_W + ATK_REACH. The enemy is hit if x < r < x + ENEMY_W.
  - Facing left: reach point r = player_x - ATK_REACH, saturating at 0. The enemy is hit if x < r < x + ENEMY_W.
  - Every live enemy satisfying the test loses 1 hp.
  - At hp 0 the enemy goes to DYING and kills increments once per enemy.
- Simultaneous attack hit and contact in one tick: damage is applied first. An enemy killed that tick cannot set player_hit; a surviving one can.
- DYING: frame = DEAD_OFS; after DYING_TICKS anim_ticks go to DEAD.
- DEAD: frame and x held; alive = 0; no contact, no hits.
- Animation, on anim_tick:
  - WALK_R: frame = RIGHT_BASE + idx*FRAME_STRIDE. WALK_L: frame = LEFT_BASE + idx*FRAME_STRIDE.
  - idx wraps modulo WALK_FRAMES and resets to 0 on a direction change.
  - ATTACK: frame = ATK_R_OFS if the enemy last moved right, else ATK_L_OFS.
- level_clear: set the cycle after all enemies are DEAD, only if level_start has occurred since reset. It stays set until level_start.
- Latency: all outputs registered; one cycle after the tick/anim_tick that causes the change.
- Reset or level_start mid-DYING or mid-ATTACK: immediate respawn or reset as above; no partial state is kept.

Decomposition:
- Shared package game_pkg:
  - enemy state enum (WALK_L = 0, WALK_R = 1, ATTACK = 2, DYING = 3, DEAD = 4, 3 bits).
  - Frame-offset constants.
  - Screen bounds (640x480, ground 440).
- Sub-module enemy_actor: a single-enemy FSM with hp, anim index, x/y, frame and a hit-request input. It is instantiated N_ENEMIES times in a generate loop.
- The top keeps: attack edge detect, hit-test fan-out, player_hit/level_clear/kills reduction.

Test Plan:
- Reset then level_start with spawn_x[0] = 600, SPEED = 7, player far away -> after 1 tick x0 = 593; frame walks 250, 300, 350, 400, 250 over anim_ticks.
- Enemy walking left reaches X_MIN -> x clamps to 10, state WALK_R, frame becomes 0 on the next anim_tick; symmetric clamp at 580.
- Player_x = 200, player_y = spawn_y, enemy walks into player -> ATTACK, frame 450, player_hit = 1; same overlap with player_y differing by 60 -> player_hit stays 0.
- Facing = 1, player_x = 200, enemy at x = 230, HP_INIT = 3; three attack presses (held 5 ticks each) -> exactly 3 decrements, DYING, frame 600, kills = 1, alive[0] = 0 after 8 anim_ticks.
- Killing attack and contact on the same tick -> enemy DYING, player_hit remains 0.
- Kill all N_ENEMIES -> level_clear = 1 one cycle after the last DEAD; a following level_start clears level_clear and kills and respawns all enemies at spawn_x.
